// File: rtl/fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe
// Three-stage pipelined floating-point multiplier with generic exponent and
// mantissa widths. It sits between the operand issue logic and the result
// writeback.
//
// Stages:
//    S1  unpack operands and classify them as zero, Inf or NaN
//    S2  form the biased exponent sum and the full significand product
//    S3  normalise, round, detect overflow/underflow, resolve special values,
//        and pack the result into the output register
//
// Configuration macro:
//    FP_MUL_ROUND_EN  defined   -> round to nearest, ties to even
//                     undefined -> truncate (round toward zero)
//
// Ports:
//    clk        in   clock; all logic is on the rising edge
//    rst        in   synchronous reset, active-high
//    in_valid   in   operand pair a/b is valid
//    in_ready   out  the block accepts a/b this cycle
//    a, b       in   operands {sign, exp, man}
//    out_valid  out  m and the flags are valid
//    out_ready  in   the consumer accepts m this cycle
//    m          out  product a*b
//    overflow   out  result above max finite; m = +/-Inf
//    underflow  out  result below min normal; m = +/-0
//    invalid    out  NaN operand or Inf*0; m = canonical quiet NaN
// -----------------------------------------------------------------------------
module fp_mul_pipe #(
   parameter  int EXP_W      = 8,
   parameter  int MAN_W      = 23,
   localparam int DATA_WIDTH = 1 + EXP_W + MAN_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] m,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  invalid
);

   // The exponent is carried signed with two extra bits. This leaves room for
   // the sum of two biased exponents and for results that fall below zero.
   localparam int EW = EXP_W + 2;
   localparam int PW = 2 * MAN_W + 2;

   localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ZERO   = '0;
   localparam logic [EXP_W-1:0]     EXP_ONES = '1;
   localparam logic [EXP_W-1:0]     EXP_NIL  = '0;
   localparam logic [MAN_W-1:0]     MAN_NIL  = '0;
   localparam logic [MAN_W-1:0]     MAN_QNAN = {1'b1, {(MAN_W - 1){1'b0}}};

   // The whole pipe advances together. No stage squeezes out a bubble on its own.
   logic w_adv;

   // ---------------------------------------------------------------- S1 unpack
   logic [DATA_WIDTH-1:0] w_op   [2];
   logic [EXP_W-1:0]      w_exp  [2];
   logic [MAN_W-1:0]      w_man  [2];
   logic                  w_zero [2];
   logic                  w_nan  [2];
   logic                  w_inf  [2];

   assign w_op[0] = a;
   assign w_op[1] = b;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         assign w_exp[gi]  = w_op[gi][DATA_WIDTH-2 -: EXP_W];
         assign w_man[gi]  = w_op[gi][MAN_W-1:0];
         // A zero exponent field covers true zeros and subnormals. Both are
         // flushed to zero, and the sign is kept.
         assign w_zero[gi] = (w_exp[gi] == EXP_NIL);
         assign w_nan[gi]  = (w_exp[gi] == EXP_ONES) && (w_man[gi] != MAN_NIL);
         assign w_inf[gi]  = (w_exp[gi] == EXP_ONES) && (w_man[gi] == MAN_NIL);
      end
   endgenerate

   logic w_s1_sign;
   logic w_s1_inv;
   logic w_s1_inf;
   logic w_s1_zero;

   assign w_s1_sign = w_op[0][DATA_WIDTH-1] ^ w_op[1][DATA_WIDTH-1];
   assign w_s1_inf  = w_inf[0] | w_inf[1];
   assign w_s1_zero = w_zero[0] | w_zero[1];
   assign w_s1_inv  = w_nan[0] | w_nan[1] | (w_s1_inf & w_s1_zero);

   logic             r_s1_valid;
   logic             r_s1_sign;
   logic             r_s1_inv;
   logic             r_s1_inf;
   logic             r_s1_zero;
   logic [EXP_W-1:0] r_s1_ea;
   logic [EXP_W-1:0] r_s1_eb;
   logic [MAN_W-1:0] r_s1_ma;
   logic [MAN_W-1:0] r_s1_mb;

   // ------------------------------------------------------------ S2 arithmetic
   logic signed [EW-1:0] w_s2_e;
   logic [PW-1:0]        w_s2_p;

   assign w_s2_e = $signed({2'b00, r_s1_ea}) + $signed({2'b00, r_s1_eb}) - BIAS;
   assign w_s2_p = PW'({1'b1, r_s1_ma}) * PW'({1'b1, r_s1_mb});

   logic                 r_s2_valid;
   logic                 r_s2_sign;
   logic                 r_s2_inv;
   logic                 r_s2_inf;
   logic                 r_s2_zero;
   logic signed [EW-1:0] r_s2_e;
   logic [PW-1:0]        r_s2_p;

   // ------------------------------------------------ S3 normalise/round/pack
   // The product of two significands in [1,2) lies in [1,4). The top bit
   // selects which window of the product becomes the significand.
   logic                 w_norm;
   logic [MAN_W:0]       w_sig;
   logic                 w_guard;
   logic                 w_sticky;
   logic                 w_inc;
   logic [MAN_W+1:0]     w_sum;
   logic                 w_carry;
   logic [MAN_W-1:0]     w_frac;
   logic signed [EW-1:0] w_e3;
   logic                 w_ovf;
   logic                 w_unf;

   assign w_norm   = r_s2_p[PW-1];
   assign w_sig    = w_norm ? r_s2_p[PW-1 -: MAN_W+1] : r_s2_p[PW-2 -: MAN_W+1];
   assign w_guard  = w_norm ? r_s2_p[MAN_W] : r_s2_p[MAN_W-1];
   assign w_sticky = w_norm ? (|r_s2_p[MAN_W-1:0]) : (|r_s2_p[MAN_W-2:0]);

`ifdef FP_MUL_ROUND_EN
   assign w_inc = w_guard & (w_sticky | w_sig[0]);
`else
   // Truncation ignores the guard and sticky bits. They are still formed so
   // that the datapath stays the same in both builds.
   logic w_unused_rnd;
   assign w_unused_rnd = w_guard ^ w_sticky;
   assign w_inc        = 1'b0;
`endif

   assign w_sum   = {1'b0, w_sig} + {{(MAN_W + 1){1'b0}}, w_inc};
   // A carry out of rounding gives exactly 2.0. Renormalise by one place.
   assign w_carry = w_sum[MAN_W+1];
   assign w_frac  = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
   assign w_e3    = r_s2_e
                  + $signed({{(EW - 1){1'b0}}, w_norm})
                  + $signed({{(EW - 1){1'b0}}, w_carry});
   assign w_ovf   = (w_e3 >= E_MAX);
   assign w_unf   = (w_e3 <= E_ZERO);

   logic [DATA_WIDTH-1:0] w_res_m;
   logic                  w_res_ovf;
   logic                  w_res_unf;
   logic                  w_res_inv;

   // Special operands take priority over any arithmetic result. Because the
   // chain is exclusive, at most one flag can be set.
   always_comb begin
      w_res_m   = {r_s2_sign, w_e3[EXP_W-1:0], w_frac};
      w_res_ovf = 1'b0;
      w_res_unf = 1'b0;
      w_res_inv = 1'b0;
      if (r_s2_inv) begin
         w_res_m   = {1'b0, EXP_ONES, MAN_QNAN};
         w_res_inv = 1'b1;
      end else if (r_s2_inf) begin
         w_res_m = {r_s2_sign, EXP_ONES, MAN_NIL};
      end else if (r_s2_zero) begin
         w_res_m = {r_s2_sign, EXP_NIL, MAN_NIL};
      end else if (w_ovf) begin
         w_res_m   = {r_s2_sign, EXP_ONES, MAN_NIL};
         w_res_ovf = 1'b1;
      end else if (w_unf) begin
         w_res_m   = {r_s2_sign, EXP_NIL, MAN_NIL};
         w_res_unf = 1'b1;
      end
   end

   logic                  r_s3_valid;
   logic [DATA_WIDTH-1:0] r_m;
   logic                  r_ovf;
   logic                  r_unf;
   logic                  r_inv;

   assign w_adv = !r_s3_valid | out_ready;

   // Valid bits and the visible outputs are reset. When the pipe is stalled,
   // they keep their values because every register is enabled by w_adv.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s3_valid <= 1'b0;
         r_m        <= '0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
         r_inv      <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         r_s2_valid <= r_s1_valid;
         r_s3_valid <= r_s2_valid;
         r_m        <= w_res_m;
         r_ovf      <= w_res_ovf;
         r_unf      <= w_res_unf;
         r_inv      <= w_res_inv;
      end
   end

   // Datapath registers need no reset. Their contents matter only when a
   // valid bit is set, and the valid bits are reset.
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_s1_sign <= w_s1_sign;
         r_s1_inv  <= w_s1_inv;
         r_s1_inf  <= w_s1_inf;
         r_s1_zero <= w_s1_zero;
         r_s1_ea   <= w_exp[0];
         r_s1_eb   <= w_exp[1];
         r_s1_ma   <= w_man[0];
         r_s1_mb   <= w_man[1];
         r_s2_sign <= r_s1_sign;
         r_s2_inv  <= r_s1_inv;
         r_s2_inf  <= r_s1_inf;
         r_s2_zero <= r_s1_zero;
         r_s2_e    <= w_s2_e;
         r_s2_p    <= w_s2_p;
      end
   end

   assign in_ready  = w_adv;
   assign out_valid = r_s3_valid;
   assign m         = r_m;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
   assign invalid   = r_inv;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_pipe
// Scoreboard bench for fp_mul_pipe using the binary32 defaults. Each accepted
// operand pair pushes its hand-derived expected result, packed as
// {invalid, overflow, underflow, m}. A monitor pops and compares the oldest
// entry on every output transfer. Outputs are sampled on the falling edge.
// Inputs change 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] m;
   logic        overflow;
   logic        underflow;
   logic        invalid;

   always #5 clk = ~clk;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .m         (m),
      .overflow  (overflow),
      .underflow (underflow),
      .invalid   (invalid)
   );

   // Vector table: operands, expected product, expected flags {inv, ovf, unf}.
   localparam int NV = 16;
   logic [31:0] va [NV];
   logic [31:0] vb [NV];
   logic [31:0] vm [NV];
   logic [2:0]  vf [NV];

   logic [34:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_recv   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
      end
   endtask

   task automatic set_vec(input int i, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [31:0] tm, input logic [2:0] tf);
      va[i] = ta;
      vb[i] = tb_;
      vm[i] = tm;
      vf[i] = tf;
   endtask

   // Offer one operand pair and wait a bounded time for it to be accepted.
   task automatic send(input int i);
      int w;
      a        = va[i];
      b        = vb[i];
      in_valid = 1'b1;
      w        = 0;
      forever begin
         @(negedge clk);
         if (in_ready || w > 100) break;
         w++;
      end
      if (!in_ready) check_val("send_accept", 64'(in_ready), 64'(1));
      else           exp_q.push_back({vf[i], vm[i]});
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(posedge clk);
         w++;
      end
      #2;
      check_val("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   // Output monitor. It compares each result with the scoreboard and checks
   // that outputs hold while the consumer stalls.
   initial begin
      logic        stall_prev;
      logic [34:0] held;
      logic [34:0] got;
      logic [34:0] e;
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         got = {invalid, overflow, underflow, m};
         if (!rst) begin
            if (stall_prev && out_valid) check_val("hold_stable", 64'(got), 64'(held));
            if (out_valid && out_ready) begin
               check_val("out_expected", 64'(exp_q.size() != 0), 64'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  $display("out %0d m=%h inv/ovf/unf=%b expected m=%h inv/ovf/unf=%b",
                           n_recv, got[31:0], got[34:32], e[31:0], e[34:32]);
                  check_val($sformatf("result%0d", n_recv), 64'(got), 64'(e));
               end
               n_recv++;
            end
            stall_prev = out_valid && !out_ready;
            held       = got;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      int  recv0;
      bit  done;
      bit  dropped;

      set_vec( 0, 32'h3F800000, 32'h40000000, 32'h40000000, 3'b000);
      set_vec( 1, 32'h3C2F0000, 32'h00000000, 32'h00000000, 3'b000);
      set_vec( 2, 32'hBF800000, 32'h00000000, 32'h80000000, 3'b000);
      set_vec( 3, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
      set_vec( 4, 32'h7F900000, 32'h4FF00800, 32'h7FC00000, 3'b100);
      set_vec( 5, 32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010);
      set_vec( 6, 32'h00800000, 32'h3F000000, 32'h00000000, 3'b001);
`ifdef FP_MUL_ROUND_EN
      set_vec( 7, 32'h3FC00001, 32'h3FC00001, 32'h40100002, 3'b000);
`else
      set_vec( 7, 32'h3FC00001, 32'h3FC00001, 32'h40100001, 3'b000);
`endif
      set_vec( 8, 32'h40400000, 32'h40400000, 32'h41100000, 3'b000);
      set_vec( 9, 32'hC0000000, 32'h40800000, 32'hC1000000, 3'b000);
      set_vec(10, 32'h3F800000, 32'hFF800000, 32'hFF800000, 3'b000);
      set_vec(11, 32'hFF800000, 32'h80000000, 32'h7FC00000, 3'b100);
      set_vec(12, 32'h00400000, 32'h40000000, 32'h00000000, 3'b000);
      set_vec(13, 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
      set_vec(14, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 3'b100);
      set_vec(15, 32'h80000000, 32'hC0000000, 32'h00000000, 3'b000);

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_out_valid", 64'(out_valid), 64'(0));
      check_val("rst_m", 64'(m), 64'(0));
      check_val("rst_flags", 64'({invalid, overflow, underflow}), 64'(0));
      check_val("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Latency: the result appears after the third edge, counting the accept edge.
      a        = va[0];
      b        = vb[0];
      in_valid = 1'b1;
      @(negedge clk);
      check_val("lat_in_ready", 64'(in_ready), 64'(1));
      exp_q.push_back({vf[0], vm[0]});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_val("latency", 64'(lat), 64'(3));
      @(posedge clk);
      #2;

      // Back-to-back stream with the consumer always ready.
      for (int i = 1; i < NV; i++) send(i);
      drain();

      // The full table again, with random backpressure.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < NV; i++) send(i);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #2;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Six pairs into a stalled consumer: the pipe fills, in_ready drops,
      // and all six results drain in order.
      out_ready = 1'b0;
      dropped   = 1'b0;
      recv0     = n_recv;
      fork
         begin
            for (int i = 2; i < 8; i++) send(i);
         end
         begin
            repeat (5) @(posedge clk);
            #2;
            out_ready = 1'b1;
         end
         begin
            repeat (8) begin
               @(negedge clk);
               if (in_valid && !in_ready) dropped = 1'b1;
            end
         end
      join
      drain();
      check_val("in_ready_dropped", 64'(dropped), 64'(1));
      check_val("fill_count", 64'(n_recv - recv0), 64'(6));

      // Reset mid-stream: results in flight are discarded.
      send(8);
      send(9);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_val("rst_flush", 64'(out_valid), 64'(0));
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check_val("rst_quiet", 64'(out_valid), 64'(0));
      end
      @(posedge clk);
      #2;
      send(13);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
